// File: rtl/button_input.sv
// ---------------------------------------------------------------------------
// button_input
//
// Debounced push-button front end for a CPU port_in register.
//
// Each active-low button is brought into the clk domain by a two-flop
// synchronizer, then debounced: a new level is accepted only after the
// synchronized input has disagreed with the current debounced level for
// DEBOUNCE_CYCLES consecutive cycles. Debounced edges raise sticky per-button
// press/release flags. The CPU clears these flags with a masked acknowledge.
// A wrapping 8-bit counter tallies press events.
//
// Parameters
//   WIDTH_IN         number of buttons
//   WIDTH_REG        width of the status word (3*WIDTH_IN+8 <= WIDTH_REG)
//   DEBOUNCE_CYCLES  stable cycles needed to accept a new level (>= 2)
//
// Ports
//   clk           system clock; all state changes on its rising edge
//   reset         asynchronous reset, active low
//   btn_raw       raw button inputs, active low (0 = pressed)
//   ack_valid     one-cycle request to clear the flags selected by ack_mask
//   ack_mask      per-button select for ack_valid
//   port_in_data  status word:
//                   [WIDTH_IN-1:0]            pressed level (1 = pressed)
//                   [2*WIDTH_IN-1:WIDTH_IN]   press flags
//                   [3*WIDTH_IN-1:2*WIDTH_IN] release flags
//                   [WIDTH_REG-1:WIDTH_REG-8] press count
//                   all other bits 0
//   irq           registered OR of the press flags
// ---------------------------------------------------------------------------
module button_input #(
  parameter int unsigned WIDTH_IN        = 4,
  parameter int unsigned WIDTH_REG       = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 240000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH_IN-1:0]  btn_raw,
  input  logic                 ack_valid,
  input  logic [WIDTH_IN-1:0]  ack_mask,
  output logic [WIDTH_REG-1:0] port_in_data,
  output logic                 irq
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  // Synchronizer and debounce state
  logic [WIDTH_IN-1:0]           sync1_q, sync2_q;
  logic [WIDTH_IN-1:0]           stable_q, stable_d;
  // Previous debounced level, used to detect debounced edges
  logic [WIDTH_IN-1:0]           stable_dly_q;
  logic [WIDTH_IN-1:0][CntW-1:0] cnt_q, cnt_d;

  // Event flags and counter
  logic [WIDTH_IN-1:0]  press_flag_q, press_flag_d;
  logic [WIDTH_IN-1:0]  release_flag_q, release_flag_d;
  logic [7:0]           press_count_q, press_count_d;

  // Output registers
  logic [WIDTH_REG-1:0] port_q, port_d;
  logic                 irq_q, irq_d;

  logic [WIDTH_IN-1:0]  press_evt, release_evt, ack_clr;
  logic [7:0]           n_press;

  // Debounce: count consecutive disagreeing cycles, accept on the last one.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    for (int i = 0; i < WIDTH_IN; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  // Buttons are active low: a falling debounced level is a press.
  assign press_evt   = stable_dly_q & ~stable_q;
  assign release_evt = ~stable_dly_q & stable_q;
  assign ack_clr     = ack_valid ? ack_mask : '0;

  always_comb begin
    n_press = '0;
    for (int i = 0; i < WIDTH_IN; i++) begin
      n_press = n_press + 8'(press_evt[i]);
    end
  end

  // Set is ORed in after the clear so a same-cycle event wins over an ack.
  always_comb begin
    press_flag_d   = (press_flag_q & ~ack_clr) | press_evt;
    release_flag_d = (release_flag_q & ~ack_clr) | release_evt;
    press_count_d  = press_count_q + n_press;
    irq_d          = |press_flag_q;
  end

  // The status word is built from next-state values so it changes on the
  // same edge as the internal level, flag and counter registers.
  always_comb begin
    port_d                                  = '0;
    port_d[WIDTH_IN-1:0]                    = ~stable_d;
    port_d[2*WIDTH_IN-1 -: WIDTH_IN]        = press_flag_d;
    port_d[3*WIDTH_IN-1 -: WIDTH_IN]        = release_flag_d;
    port_d[WIDTH_REG-1 -: 8]                = press_count_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q        <= '1;
      sync2_q        <= '1;
      stable_q       <= '1;
      stable_dly_q   <= '1;
      cnt_q          <= '0;
      press_flag_q   <= '0;
      release_flag_q <= '0;
      press_count_q  <= '0;
      port_q         <= '0;
      irq_q          <= 1'b0;
    end else begin
      sync1_q        <= btn_raw;
      sync2_q        <= sync1_q;
      stable_q       <= stable_d;
      stable_dly_q   <= stable_q;
      cnt_q          <= cnt_d;
      press_flag_q   <= press_flag_d;
      release_flag_q <= release_flag_d;
      press_count_q  <= press_count_d;
      port_q         <= port_d;
      irq_q          <= irq_d;
    end
  end

  assign port_in_data = port_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_button_input.sv
module tb_button_input;

  localparam int W  = 4;
  localparam int WR = 32;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  btn_raw;
  logic          ack_valid;
  logic [W-1:0]  ack_mask;
  logic [WR-1:0] port_in_data;
  logic          irq;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: each button's raw level reaches the debouncer two edges
  // late; a new level is accepted once it has disagreed with the accepted
  // level for D consecutive edges. Events land in the flags one edge later.
  logic [W-1:0] m_d1, m_d2, m_lvl, m_pend_p, m_pend_r, m_pf, m_rf;
  int           m_run[W];
  logic [7:0]   m_cnt;
  logic         m_irq;

  button_input #(
    .WIDTH_IN       (W),
    .WIDTH_REG      (WR),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .ack_valid   (ack_valid),
    .ack_mask    (ack_mask),
    .port_in_data(port_in_data),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_d1     = '1;
    m_d2     = '1;
    m_lvl    = '1;
    m_pend_p = '0;
    m_pend_r = '0;
    m_pf     = '0;
    m_rf     = '0;
    m_cnt    = '0;
    m_irq    = 1'b0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
  endtask

  task automatic model_edge();
    logic [W-1:0] clr;
    if (!reset) begin
      model_reset();
    end else begin
      clr      = ack_valid ? ack_mask : '0;
      m_irq    = |m_pf;
      m_pf     = (m_pf & ~clr) | m_pend_p;
      m_rf     = (m_rf & ~clr) | m_pend_r;
      m_cnt    = m_cnt + 8'($countones(m_pend_p));
      m_pend_p = '0;
      m_pend_r = '0;
      for (int i = 0; i < W; i++) begin
        if (m_d2[i] == m_lvl[i]) begin
          m_run[i] = 0;
        end else begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_lvl[i] = m_d2[i];
            m_run[i] = 0;
            if (m_d2[i]) m_pend_r[i] = 1'b1;
            else         m_pend_p[i] = 1'b1;
          end
        end
      end
      m_d2 = m_d1;
      m_d1 = btn_raw;
    end
  endtask

  function automatic logic [WR-1:0] exp_word();
    logic [WR-1:0] w;
    w        = '0;
    w[3:0]   = ~m_lvl;
    w[7:4]   = m_pf;
    w[11:8]  = m_rf;
    w[31:24] = m_cnt;
    return w;
  endfunction

  // One clock edge; returns 1 ns after the edge with the model updated.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    btn_raw   = '1;
    ack_valid = 1'b0;
    ack_mask  = '0;
    model_reset();
    #1;
    compared++;
    if (port_in_data !== '0 || irq !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_hold: port=%h irq=%b want 0/0", port_in_data, irq);
    end
    repeat (3) step();
    reset = 1'b1;
    repeat (10) step();
    compared++;
    if (port_in_data !== '0 || irq !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release_quiet: port=%h irq=%b want 0/0", port_in_data, irq);
    end
  endtask

  task automatic test_press_latency();
    btn_raw = 4'b1110;
    for (int e = 1; e <= 6; e++) begin
      step();
      compared++;
      if (port_in_data[0] !== (e == 6)) begin
        mismatched++;
        $display("FAIL latency edge %0d: level0=%b want %b", e, port_in_data[0], e == 6);
      end
    end
    step();
    compared++;
    if (port_in_data[4] !== 1'b1 || irq !== 1'b0) begin
      mismatched++;
      $display("FAIL press_flag_timing: pf0=%b irq=%b want 1/0", port_in_data[4], irq);
    end
    step();
    compared++;
    if (irq !== 1'b1 || port_in_data[31:24] !== 8'd1 || port_in_data !== exp_word()) begin
      mismatched++;
      $display("FAIL irq_count: irq=%b cnt=%0d port=%h want 1/1/%h",
               irq, port_in_data[31:24], port_in_data, exp_word());
    end
  endtask

  task automatic test_glitch();
    btn_raw = 4'b1100;
    repeat (3) step();
    btn_raw = 4'b1110;
    for (int e = 0; e < 10; e++) begin
      step();
      compared++;
      if (port_in_data !== exp_word() || irq !== m_irq) begin
        mismatched++;
        $display("FAIL glitch_model edge %0d: port=%h irq=%b want %h/%b",
                 e, port_in_data, irq, exp_word(), m_irq);
      end
    end
    compared++;
    if (port_in_data[1] !== 1'b0 || port_in_data[5] !== 1'b0 || port_in_data[31:24] !== 8'd1) begin
      mismatched++;
      $display("FAIL glitch_rejected: lvl1=%b pf1=%b cnt=%0d want 0/0/1",
               port_in_data[1], port_in_data[5], port_in_data[31:24]);
    end
  endtask

  task automatic test_ack();
    btn_raw = 4'b1010;
    repeat (8) step();
    btn_raw = 4'b1110;
    repeat (8) step();
    compared++;
    if (port_in_data[10] !== 1'b1 || port_in_data[2] !== 1'b0 || port_in_data[6] !== 1'b1) begin
      mismatched++;
      $display("FAIL press_release2: rf2=%b lvl2=%b pf2=%b want 1/0/1",
               port_in_data[10], port_in_data[2], port_in_data[6]);
    end
    // Mask without ack_valid must be ignored.
    ack_mask = 4'b1111;
    step();
    compared++;
    if (port_in_data[11:4] !== 8'b0100_0101) begin
      mismatched++;
      $display("FAIL ack_ignored: flags=%b want 01000101", port_in_data[11:4]);
    end
    ack_valid = 1'b1;
    ack_mask  = 4'b0100;
    step();
    ack_valid = 1'b0;
    compared++;
    if (port_in_data[6] !== 1'b0 || port_in_data[10] !== 1'b0 || port_in_data[4] !== 1'b1
        || port_in_data !== exp_word()) begin
      mismatched++;
      $display("FAIL ack_mask2: port=%h want %h", port_in_data, exp_word());
    end
    ack_valid = 1'b1;
    ack_mask  = 4'b0001;
    step();
    ack_valid = 1'b0;
    step();
    compared++;
    if (irq !== 1'b0 || port_in_data[7:4] !== 4'b0000) begin
      mismatched++;
      $display("FAIL ack_irq_drop: irq=%b pf=%b want 0/0000", irq, port_in_data[7:4]);
    end
  endtask

  task automatic test_ack_collision();
    btn_raw = 4'b1111;
    repeat (8) step();
    compared++;
    if (port_in_data[8] !== 1'b1 || port_in_data[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL release0: rf0=%b lvl0=%b want 1/0", port_in_data[8], port_in_data[0]);
    end
    btn_raw = 4'b1110;
    repeat (6) step();
    ack_valid = 1'b1;
    ack_mask  = 4'b0001;
    step();
    ack_valid = 1'b0;
    compared++;
    if (port_in_data[4] !== 1'b1 || port_in_data[8] !== 1'b0 || port_in_data !== exp_word()) begin
      mismatched++;
      $display("FAIL set_beats_ack: pf0=%b rf0=%b port=%h want 1/0/%h",
               port_in_data[4], port_in_data[8], port_in_data, exp_word());
    end
  endtask

  task automatic test_wrap();
    reset = 1'b0;
    #1;
    model_reset();
    btn_raw = 4'b1111;
    repeat (2) step();
    reset = 1'b1;
    for (int p = 1; p <= 256; p++) begin
      btn_raw = 4'b0111;
      repeat (7) step();
      btn_raw = 4'b1111;
      for (int e = 0; e < 7; e++) begin
        step();
        compared++;
        if (port_in_data !== exp_word() || irq !== m_irq) begin
          mismatched++;
          $display("FAIL wrap_model press %0d: port=%h irq=%b want %h/%b",
                   p, port_in_data, irq, exp_word(), m_irq);
        end
      end
      if (p == 255) begin
        compared++;
        if (port_in_data[31:24] !== 8'd255) begin
          mismatched++;
          $display("FAIL count_255: cnt=%0d want 255", port_in_data[31:24]);
        end
      end
    end
    compared++;
    if (port_in_data[31:24] !== 8'd0 || port_in_data[7] !== 1'b1) begin
      mismatched++;
      $display("FAIL count_wrap: cnt=%0d pf3=%b want 0/1", port_in_data[31:24], port_in_data[7]);
    end
  endtask

  task automatic test_reset_mid();
    btn_raw = 4'b1110;
    repeat (5) step();
    compared++;
    if (port_in_data[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL pre_reset_level: lvl0=%b want 0", port_in_data[0]);
    end
    reset = 1'b0;
    #1;
    model_reset();
    compared++;
    if (port_in_data !== '0 || irq !== 1'b0) begin
      mismatched++;
      $display("FAIL async_reset: port=%h irq=%b want 0/0", port_in_data, irq);
    end
    repeat (2) step();
    reset = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      compared++;
      if (port_in_data[0] !== (e == 6)) begin
        mismatched++;
        $display("FAIL post_reset_latency edge %0d: lvl0=%b want %b", e, port_in_data[0], e == 6);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    for (int n = 0; n < 200; n++) begin
      btn_raw = 4'($urandom);
      hold    = $urandom_range(1, 10);
      for (int k = 0; k < hold; k++) begin
        ack_valid = ($urandom_range(0, 7) == 0);
        ack_mask  = 4'($urandom);
        step();
        compared++;
        if (port_in_data !== exp_word() || irq !== m_irq) begin
          mismatched++;
          $display("FAIL random iter %0d: port=%h irq=%b want %h/%b",
                   n, port_in_data, irq, exp_word(), m_irq);
        end
      end
    end
    ack_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_glitch();
    test_ack();
    test_ack_collision();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/button_input.md
BUTTON_INPUT -- requirements
Module: button_input

Interface
REQ-001 Parameter WIDTH_IN, default 4: number of push-button inputs.
REQ-002 Parameter WIDTH_REG, default 32: width of the CPU port_in word; 3*WIDTH_IN+8 <= WIDTH_REG is required.
REQ-003 Parameter DEBOUNCE_CYCLES, default 240000: consecutive stable cycles needed to accept a new level; minimum 2.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 btn_raw  input  WIDTH_IN  raw asynchronous buttons, active-low (0 = pressed).
REQ-007 ack_valid  input  1  one-cycle pulse requesting that event flags be cleared.
REQ-008 ack_mask  input  WIDTH_IN  selects which button flags ack_valid clears.
REQ-009 port_in_data  output  WIDTH_REG  status word for the CPU port_in.
REQ-010 irq  output  1  registered; 1 while any press flag is set.

Function
REQ-011 Each btn_raw bit SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-012 Each bit SHALL keep a debounced register "stable" and a counter sized ceil(log2(DEBOUNCE_CYCLES)) bits.
- sync2 == stable: counter SHALL be cleared to 0.
- sync2 != stable and counter < DEBOUNCE_CYCLES-1: counter SHALL increment.
- sync2 != stable and counter == DEBOUNCE_CYCLES-1: stable SHALL take sync2 and counter SHALL clear.
REQ-013 A glitch shorter than DEBOUNCE_CYCLES cycles at sync2 SHALL NOT change stable; any return to the stable level restarts the count from 0.
REQ-014 Latency: a clean raw edge SHALL change stable exactly DEBOUNCE_CYCLES+2 clock edges after the first edge that samples it into sync1.
REQ-015 Press event = stable 1->0; release event = stable 0->1. Each event SHALL set the matching per-bit sticky flag (press_flag or release_flag) on the edge after stable changes.
REQ-016 On ack_valid=1, flags whose ack_mask bit is 1 SHALL clear on that edge; flags with ack_mask bit 0 are unaffected; ack_valid=0 ignores ack_mask.
REQ-017 Same cycle event set and ack clear on one flag: set SHALL win and the flag stays 1.
REQ-018 press_count (8 bits) SHALL add the number of press events occurring that cycle (0..WIDTH_IN), wrapping modulo 256 (255+1 -> 0); ack does not clear it.
REQ-019 port_in_data layout, all registered:
- [WIDTH_IN-1:0] = ~stable (1 = pressed)
- [2*WIDTH_IN-1:WIDTH_IN] = press_flag
- [3*WIDTH_IN-1:2*WIDTH_IN] = release_flag
- [WIDTH_REG-1:WIDTH_REG-8] = press_count
- all other bits = 0
REQ-020 irq SHALL be the OR of press_flag, registered, updating on the same edge as the flags are visible plus one cycle.
REQ-021 Level, flags and counter bits of port_in_data SHALL be glitch-free register outputs; there is no combinational path from btn_raw or ack inputs to outputs.

Reset
REQ-022 reset=0 SHALL immediately, asynchronously force sync1, sync2 and stable to 1 (released), and force counters, flags, press_count, port_in_data and irq to 0.
REQ-023 Reset asserted mid-debounce SHALL discard the partial count; after release, a held-low button SHALL need the full DEBOUNCE_CYCLES+2 cycles again.
REQ-024 Release of reset is synchronized externally; the block resumes on the first clk edge with reset=1 and does not generate events caused by reset itself.

Verification (bench with WIDTH_IN=4, DEBOUNCE_CYCLES=4)
REQ-025 Hold btn_raw=4'b1110 steady -> port_in_data[0]=1 exactly 6 edges after first sample, press_flag[0]=1 and irq=1 after that, press_count=1.
REQ-026 Pulse btn_raw[1]=0 for 3 cycles, then 1 -> port_in_data stays 0, no flags, press_count=0.
REQ-027 Press and release button 2 -> release_flag[2]=1 and level bit 2 back to 0. Then ack_valid=1 with ack_mask=4'b0100 -> bits 6 and 10 clear, other flags kept, irq=0 if no other press flag.
REQ-028 Ack of bit 0 on the same edge as a new press event on bit 0 -> press_flag[0] remains 1.
REQ-029 Generate 256 debounced presses of button 3 -> press_count returns to 0 (wrap), press_flag[3]=1.
REQ-030 Assert reset=0 while a button has counted 3 of 4 cycles -> all outputs 0 at once. After reset=1 with the button still held, level asserts only after 6 more edges.
